// File: rtl/cpu_pkg.sv
// Shared decode definitions: control bundle, opcode/funct encodings,
// ALU and branch codes, and immediate extension helper.
package cpu_pkg;

  localparam int unsigned ALUOP_W = 4;

  typedef struct packed {
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               alu_src_imm;
    logic [ALUOP_W-1:0] alu_op;
    logic [2:0]         branch;
    logic               link;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  // ALU operations; zero is reserved for "no operation"
  localparam logic [ALUOP_W-1:0] ALU_NONE = 4'd0;
  localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'd1;
  localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'd2;
  localparam logic [ALUOP_W-1:0] ALU_AND  = 4'd3;
  localparam logic [ALUOP_W-1:0] ALU_OR   = 4'd4;
  localparam logic [ALUOP_W-1:0] ALU_XOR  = 4'd5;
  localparam logic [ALUOP_W-1:0] ALU_NOR  = 4'd6;
  localparam logic [ALUOP_W-1:0] ALU_SLT  = 4'd7;
  localparam logic [ALUOP_W-1:0] ALU_SLTU = 4'd8;
  localparam logic [ALUOP_W-1:0] ALU_SLL  = 4'd9;
  localparam logic [ALUOP_W-1:0] ALU_SRL  = 4'd10;
  localparam logic [ALUOP_W-1:0] ALU_SRA  = 4'd11;
  localparam logic [ALUOP_W-1:0] ALU_PASSB = 4'd12;

  // Branch kinds resolved downstream
  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_J    = 3'd3;
  localparam logic [2:0] BR_JR   = 3'd4;

  typedef enum logic [1:0] {EXT_SIGN, EXT_ZERO, EXT_LUI} ext_t;

  function automatic logic [31:0] ext_imm(input logic [15:0] imm, input ext_t kind);
    case (kind)
      EXT_ZERO: return {16'h0000, imm};
      EXT_LUI:  return {imm, 16'h0000};
      default:  return {{16{imm[15]}}, imm};
    endcase
  endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// Register file: two combinational read ports with write-through bypass,
// one write port; entry 0 is hard-wired to zero.
module regfile #(
  parameter int unsigned NREG = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  output logic [31:0] rd1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] mem [NREG];

  // Storage update; writes to r0 are discarded
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem <= '{default: '0};
    end else if (we && wa != '0) begin
      mem[wa] <= wd;
    end
  end

  // Read port 1 with same-cycle bypass of the WB write
  always_comb begin
    rd1 = mem[ra1];
    if (ra1 == '0)
      rd1 = '0;
    else if (we && wa == ra1)
      rd1 = wd;
  end

  // Read port 2 with same-cycle bypass of the WB write
  always_comb begin
    rd2 = mem[ra2];
    if (ra2 == '0)
      rd2 = '0;
    else if (we && wa == ra2)
      rd2 = wd;
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: decode, register read, load-use hazard
// detection, early J/JAL target and the ID/EX pipeline register.
module id_stage #(
  parameter int unsigned NREG    = 32,
  parameter int unsigned ALUOP_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [29:0]    id_pcp1,
  input  logic [31:0]    id_instr,
  input  logic           correct_at_ex,
  input  logic           correct_at_mem,
  input  logic           wb_we,
  input  logic [4:0]     wb_addr,
  input  logic [31:0]    wb_data,
  output logic           pc_write,
  output logic           if_flush,
  output logic           jpc_avail,
  output logic [29:0]    jpc,
  output logic           ex_valid,
  output logic [29:0]    ex_pcp1,
  output logic [31:0]    ex_rs_data,
  output logic [31:0]    ex_rt_data,
  output logic [31:0]    ex_imm,
  output logic [4:0]     ex_rs,
  output logic [4:0]     ex_rt,
  output logic [4:0]     ex_dst,
  output cpu_pkg::ctrl_t ex_ctrl
);

  import cpu_pkg::*;

  logic [5:0]         op;
  logic [5:0]         funct;
  logic [4:0]         rs;
  logic [4:0]         rt;
  logic [4:0]         rd;
  logic [31:0]        rs_data;
  logic [31:0]        rt_data;

  ctrl_t              dec_ctrl;
  logic [ALUOP_W-1:0] dec_alu_op;
  logic               dec_valid;
  logic               uses_rs;
  logic               uses_rt;
  logic [4:0]         dec_dst;
  ext_t               ext_kind;
  logic [31:0]        dec_imm;

  logic               flush;
  logic               stall;

  assign op    = id_instr[31:26];
  assign rs    = id_instr[25:21];
  assign rt    = id_instr[20:16];
  assign rd    = id_instr[15:11];
  assign funct = id_instr[5:0];

  regfile #(.NREG(NREG)) u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (rs),
    .rd1 (rs_data),
    .ra2 (rt),
    .rd2 (rt_data),
    .we  (wb_we),
    .wa  (wb_addr),
    .wd  (wb_data)
  );

  // Instruction decode into control bundle, destination and operand usage
  always_comb begin
    dec_ctrl   = CTRL_NOP;
    dec_alu_op = ALU_NONE;
    dec_valid  = 1'b0;
    uses_rs    = 1'b0;
    uses_rt    = 1'b0;
    dec_dst    = rt;
    ext_kind   = EXT_SIGN;

    case (op)
      OP_RTYPE: begin
        dec_dst            = rd;
        dec_valid          = 1'b1;
        uses_rs            = 1'b1;
        uses_rt            = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        case (funct)
          F_SLL:         begin dec_alu_op = ALU_SLL; uses_rs = 1'b0; end
          F_SRL:         begin dec_alu_op = ALU_SRL; uses_rs = 1'b0; end
          F_SRA:         begin dec_alu_op = ALU_SRA; uses_rs = 1'b0; end
          F_ADD, F_ADDU: dec_alu_op = ALU_ADD;
          F_SUB, F_SUBU: dec_alu_op = ALU_SUB;
          F_AND:         dec_alu_op = ALU_AND;
          F_OR:          dec_alu_op = ALU_OR;
          F_XOR:         dec_alu_op = ALU_XOR;
          F_NOR:         dec_alu_op = ALU_NOR;
          F_SLT:         dec_alu_op = ALU_SLT;
          F_SLTU:        dec_alu_op = ALU_SLTU;
          F_JR: begin
            dec_ctrl.reg_write = 1'b0;
            dec_ctrl.branch    = BR_JR;
            uses_rt            = 1'b0;
          end
          F_JALR: begin
            dec_ctrl.branch = BR_JR;
            dec_ctrl.link   = 1'b1;
            uses_rt         = 1'b0;
          end
          default: dec_valid = 1'b0;
        endcase
      end
      OP_J: begin
        dec_valid       = 1'b1;
        dec_ctrl.branch = BR_J;
      end
      OP_JAL: begin
        dec_valid          = 1'b1;
        dec_dst            = 5'd31;
        dec_ctrl.branch    = BR_J;
        dec_ctrl.link      = 1'b1;
        dec_ctrl.reg_write = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec_valid       = 1'b1;
        uses_rs         = 1'b1;
        uses_rt         = 1'b1;
        dec_alu_op      = ALU_SUB;
        dec_ctrl.branch = (op == OP_BEQ) ? BR_BEQ : BR_BNE;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        dec_valid            = 1'b1;
        uses_rs              = 1'b1;
        dec_ctrl.reg_write   = 1'b1;
        dec_ctrl.alu_src_imm = 1'b1;
        case (op)
          OP_SLTI:  dec_alu_op = ALU_SLT;
          OP_SLTIU: dec_alu_op = ALU_SLTU;
          OP_ANDI:  begin dec_alu_op = ALU_AND; ext_kind = EXT_ZERO; end
          OP_ORI:   begin dec_alu_op = ALU_OR;  ext_kind = EXT_ZERO; end
          OP_XORI:  begin dec_alu_op = ALU_XOR; ext_kind = EXT_ZERO; end
          default:  dec_alu_op = ALU_ADD;
        endcase
      end
      OP_LUI: begin
        dec_valid            = 1'b1;
        dec_ctrl.reg_write   = 1'b1;
        dec_ctrl.alu_src_imm = 1'b1;
        dec_alu_op           = ALU_PASSB;
        ext_kind             = EXT_LUI;
      end
      OP_LW: begin
        dec_valid            = 1'b1;
        uses_rs              = 1'b1;
        dec_ctrl.reg_write   = 1'b1;
        dec_ctrl.mem_read    = 1'b1;
        dec_ctrl.mem_to_reg  = 1'b1;
        dec_ctrl.alu_src_imm = 1'b1;
        dec_alu_op           = ALU_ADD;
      end
      OP_SW: begin
        dec_valid            = 1'b1;
        uses_rs              = 1'b1;
        uses_rt              = 1'b1;
        dec_ctrl.mem_write   = 1'b1;
        dec_ctrl.alu_src_imm = 1'b1;
        dec_alu_op           = ALU_ADD;
      end
      default: ;
    endcase

    dec_ctrl.alu_op = dec_alu_op;

    // The all-zero word would otherwise decode as SLL r0,r0,0
    if (!dec_valid || id_instr == '0) begin
      dec_ctrl  = CTRL_NOP;
      dec_valid = 1'b0;
      uses_rs   = 1'b0;
      uses_rt   = 1'b0;
    end
  end

  assign dec_imm = ext_imm(id_instr[15:0], ext_kind);

  // Hazard, flush and early-jump controls toward fetch
  assign flush     = correct_at_ex | correct_at_mem;
  assign stall     = ex_ctrl.mem_read & ex_valid & (ex_dst != '0)
                   & ((uses_rs & (ex_dst == rs)) | (uses_rt & (ex_dst == rt)))
                   & ~flush;
  assign pc_write  = ~stall;
  assign if_flush  = flush;
  assign jpc_avail = ((op == OP_J) || (op == OP_JAL)) & ~flush & ~stall;
  assign jpc       = {id_pcp1[29:26], id_instr[25:0]};

  // ID/EX pipeline register; flush, stall and nops all load a zeroed bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid   <= 1'b0;
      ex_pcp1    <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_dst     <= '0;
      ex_ctrl    <= CTRL_NOP;
    end else if (flush || stall || !dec_valid) begin
      ex_valid   <= 1'b0;
      ex_pcp1    <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_dst     <= '0;
      ex_ctrl    <= CTRL_NOP;
    end else begin
      ex_valid   <= 1'b1;
      ex_pcp1    <= id_pcp1;
      ex_rs_data <= rs_data;
      ex_rt_data <= rt_data;
      ex_imm     <= dec_imm;
      ex_rs      <= rs;
      ex_rt      <= rt;
      ex_dst     <= dec_dst;
      ex_ctrl    <= dec_ctrl;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for the decode stage.
module tb_id_stage;

  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] id_pcp1;
  logic [31:0] id_instr;
  logic        correct_at_ex;
  logic        correct_at_mem;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        pc_write;
  logic        if_flush;
  logic        jpc_avail;
  logic [29:0] jpc;
  logic        ex_valid;
  logic [29:0] ex_pcp1;
  logic [31:0] ex_rs_data;
  logic [31:0] ex_rt_data;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_dst;
  ctrl_t       ex_ctrl;

  int unsigned n_pass = 0;
  int unsigned n_fail = 0;
  int unsigned n_total = 0;

  id_stage #(.NREG(32), .ALUOP_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_pcp1        (id_pcp1),
    .id_instr       (id_instr),
    .correct_at_ex  (correct_at_ex),
    .correct_at_mem (correct_at_mem),
    .wb_we          (wb_we),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .pc_write       (pc_write),
    .if_flush       (if_flush),
    .jpc_avail      (jpc_avail),
    .jpc            (jpc),
    .ex_valid       (ex_valid),
    .ex_pcp1        (ex_pcp1),
    .ex_rs_data     (ex_rs_data),
    .ex_rt_data     (ex_rt_data),
    .ex_imm         (ex_imm),
    .ex_rs          (ex_rs),
    .ex_rt          (ex_rt),
    .ex_dst         (ex_dst),
    .ex_ctrl        (ex_ctrl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_we   = 1'b1;
    wb_addr = a;
    wb_data = d;
  endtask

  task automatic put(input logic [31:0] instr, input logic [29:0] pcp1);
    id_instr = instr;
    id_pcp1  = pcp1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; id_pcp1 = '0; id_instr = '0;
    correct_at_ex = 1'b0; correct_at_mem = 1'b0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    #12;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_ctrl", 32'(ex_ctrl), 32'd0);
    chk("rst_ex_pcp1", 32'(ex_pcp1), 32'd0);
    chk("rst_pc_write", 32'(pc_write), 32'd1);
    rst = 1'b1;

    // Preload r1=0x10, r5=5
    wb(5'd1, 32'h10); cyc();
    wb(5'd5, 32'h5);  cyc();
    wb_we = 1'b0;

    // ADDIU r2,r1,-4
    put(32'h2422FFFC, 30'h100); #1;
    chk("addiu_pc_write", 32'(pc_write), 32'd1);
    chk("addiu_jpc_avail", 32'(jpc_avail), 32'd0);
    cyc();
    chk("addiu_valid", 32'(ex_valid), 32'd1);
    chk("addiu_rs_data", ex_rs_data, 32'h10);
    chk("addiu_imm", ex_imm, 32'hFFFFFFFC);
    chk("addiu_dst", 32'(ex_dst), 32'd2);
    chk("addiu_rs", 32'(ex_rs), 32'd1);
    chk("addiu_pcp1", 32'(ex_pcp1), 32'h100);
    chk("addiu_reg_write", 32'(ex_ctrl.reg_write), 32'd1);
    chk("addiu_alu_src_imm", 32'(ex_ctrl.alu_src_imm), 32'd1);
    chk("addiu_mem_read", 32'(ex_ctrl.mem_read), 32'd0);

    // ORI zero-extends, LUI shifts, unknown opcode is a nop
    put(32'h34098001, 30'h101); cyc();
    chk("ori_imm", ex_imm, 32'h00008001);
    chk("ori_dst", 32'(ex_dst), 32'd9);
    put(32'h3C0A8001, 30'h102); cyc();
    chk("lui_imm", ex_imm, 32'h80010000);
    chk("lui_dst", 32'(ex_dst), 32'd10);
    put(32'hFC000000, 30'h103); cyc();
    chk("unk_valid", 32'(ex_valid), 32'd0);
    chk("unk_ctrl", 32'(ex_ctrl), 32'd0);

    // LW r3,0(r1) then ADDU r4,r3,r5: one stall, WB fills r3 during it
    put(32'h8C230000, 30'h200); cyc();
    chk("lw_mem_read", 32'(ex_ctrl.mem_read), 32'd1);
    chk("lw_dst", 32'(ex_dst), 32'd3);
    chk("lw_rs_data", ex_rs_data, 32'h10);
    put(32'h00652021, 30'h201);
    wb(5'd3, 32'h33); #1;
    chk("lu_pc_write", 32'(pc_write), 32'd0);
    cyc();
    wb_we = 1'b0;
    chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu_bubble_ctrl", 32'(ex_ctrl), 32'd0);
    #1;
    chk("lu_release_pc_write", 32'(pc_write), 32'd1);
    cyc();
    chk("addu_valid", 32'(ex_valid), 32'd1);
    chk("addu_rs_data", ex_rs_data, 32'h33);
    chk("addu_rt_data", ex_rt_data, 32'h5);
    chk("addu_dst", 32'(ex_dst), 32'd4);
    chk("addu_rt", 32'(ex_rt), 32'd5);
    chk("addu_pcp1", 32'(ex_pcp1), 32'h201);

    // LW to r0 never stalls, even when the consumer reads r0
    put(32'h8C200000, 30'h210); cyc();
    put(32'h00052021, 30'h211); #1;
    chk("lw_r0_pc_write", 32'(pc_write), 32'd1);
    cyc();
    chk("lw_r0_next_valid", 32'(ex_valid), 32'd1);
    chk("lw_r0_next_dst", 32'(ex_dst), 32'd4);

    // J: early target; then same J under flush
    put(32'h08000040, 30'h3C000001); #1;
    chk("j_avail", 32'(jpc_avail), 32'd1);
    chk("j_jpc", 32'(jpc), 32'h3C000040);
    chk("j_if_flush", 32'(if_flush), 32'd0);
    cyc();
    chk("j_ex_valid", 32'(ex_valid), 32'd1);
    correct_at_ex = 1'b1; #1;
    chk("jflush_avail", 32'(jpc_avail), 32'd0);
    chk("jflush_if_flush", 32'(if_flush), 32'd1);
    chk("jflush_pc_write", 32'(pc_write), 32'd1);
    cyc();
    correct_at_ex = 1'b0;
    chk("jflush_bubble", 32'(ex_valid), 32'd0);
    chk("jflush_ctrl", 32'(ex_ctrl), 32'd0);

    // JAL with full 26-bit target field
    put(32'h0FFFFFFF, 30'h12345678); #1;
    chk("jal_jpc", 32'(jpc), 32'h13FFFFFF);
    chk("jal_avail", 32'(jpc_avail), 32'd1);
    cyc();
    chk("jal_dst", 32'(ex_dst), 32'd31);
    chk("jal_link", 32'(ex_ctrl.link), 32'd1);
    chk("jal_reg_write", 32'(ex_ctrl.reg_write), 32'd1);

    // WB bypass on r7, writes to r0 are ignored
    put(32'h00E04021, 30'h300);
    wb(5'd7, 32'hDEADBEEF); cyc();
    chk("bypass_r7", ex_rs_data, 32'hDEADBEEF);
    put(32'h00004021, 30'h301);
    wb(5'd0, 32'h12345678); cyc();
    chk("r0_bypass_rs", ex_rs_data, 32'd0);
    chk("r0_bypass_rt", ex_rt_data, 32'd0);
    wb_we = 1'b0;
    put(32'h00E04021, 30'h302); cyc();
    chk("r7_stored", ex_rs_data, 32'hDEADBEEF);
    chk("r0_stored", ex_rt_data, 32'd0);

    // Load-use stall coinciding with a MEM-stage correction
    put(32'h8C230000, 30'h400); cyc();
    put(32'h00652021, 30'h401);
    correct_at_mem = 1'b1; #1;
    chk("fs_pc_write", 32'(pc_write), 32'd1);
    chk("fs_if_flush", 32'(if_flush), 32'd1);
    cyc();
    correct_at_mem = 1'b0;
    chk("fs_bubble", 32'(ex_valid), 32'd0);
    #1;
    chk("fs_no_extra_stall", 32'(pc_write), 32'd1);
    cyc();
    chk("fs_addu_valid", 32'(ex_valid), 32'd1);
    chk("fs_addu_dst", 32'(ex_dst), 32'd4);

    // Reset arriving mid-stall
    put(32'h8C230000, 30'h500); cyc();
    put(32'h00652021, 30'h501); #1;
    chk("rs_stall_pc_write", 32'(pc_write), 32'd0);
    rst = 1'b0; #1;
    chk("rs_ex_valid", 32'(ex_valid), 32'd0);
    chk("rs_ex_rs_data", ex_rs_data, 32'd0);
    chk("rs_ex_ctrl", 32'(ex_ctrl), 32'd0);
    chk("rs_ex_pcp1", 32'(ex_pcp1), 32'd0);
    chk("rs_pc_write", 32'(pc_write), 32'd1);
    #1;
    rst = 1'b1;
    cyc();
    chk("post_rst_valid", 32'(ex_valid), 32'd1);
    chk("post_rst_rs_data", ex_rs_data, 32'd0);
    chk("post_rst_rt_data", ex_rt_data, 32'd0);
    chk("post_rst_dst", 32'(ex_dst), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
